// File: rtl/mul_result_accumulator_if.sv
// Product-in / group-sum-out handshake bundle between the multiplier wrapper,
// the result accumulator and whatever consumes the group sums.
interface mul_result_accumulator_if #(
    parameter int DATA_W = 64,
    parameter int ACC_W  = 66,
    parameter int CNT_W  = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_data;
    logic [CNT_W-1:0]  out_cnt;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_cnt
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_cnt
    );
endinterface

// File: rtl/mul_result_accumulator.sv
// Sums groups of up to N unsigned products (closed early by in_last) and emits
// each group sum with its product count over a valid/ready output.
module mul_result_accumulator #(
    parameter int DATA_W = 64,
    parameter int N      = 4,
    parameter int ACC_W  = 66,
    parameter int CNT_W  = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    mul_result_accumulator_if.slave bus
);

    if (N < 1) begin : g_n_chk
        $error("N must be at least 1");
    end
    if (ACC_W < DATA_W + $clog2(N)) begin : g_acc_w_chk
        $error("ACC_W too narrow to hold N products without overflow");
    end
    if (N > (2 ** CNT_W) - 1) begin : g_cnt_w_chk
        $error("CNT_W too narrow to hold the value N");
    end

    typedef enum logic [1:0] {INIT, ACC, SEND} state_t;

    function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        return a + ACC_W'(b);
    endfunction

    state_t             state, state_nxt;
    logic [ACC_W-1:0]   acc_p0, acc_nxt;
    logic [CNT_W-1:0]   cnt_p0, cnt_nxt;
    logic               rdy_p0, rdy_nxt;
    logic [ACC_W-1:0]   res_data_p1, res_data_nxt;
    logic [CNT_W-1:0]   res_cnt_p1, res_cnt_nxt;
    logic               vld_p1, vld_nxt;
    logic [ACC_W-1:0]   sum;
    logic [CNT_W-1:0]   cnt_inc;
    logic               take;

    assign take    = bus.in_valid && rdy_p0;
    assign sum     = acc_add(acc_p0, bus.in_data);
    assign cnt_inc = cnt_p0 + CNT_W'(1);

    always_comb begin
        state_nxt    = state;
        acc_nxt      = acc_p0;
        cnt_nxt      = cnt_p0;
        rdy_nxt      = rdy_p0;
        res_data_nxt = res_data_p1;
        res_cnt_nxt  = res_cnt_p1;
        vld_nxt      = vld_p1;
        case (state)
            INIT: begin
                rdy_nxt   = 1'b1;
                state_nxt = ACC;
            end
            ACC: begin
                if (take) begin
                    if (cnt_inc == CNT_W'(N) || bus.in_last) begin
                        res_data_nxt = sum;
                        res_cnt_nxt  = cnt_inc;
                        vld_nxt      = 1'b1;
                        rdy_nxt      = 1'b0;
                        acc_nxt      = '0;
                        cnt_nxt      = '0;
                        state_nxt    = SEND;
                    end else begin
                        acc_nxt = sum;
                        cnt_nxt = cnt_inc;
                    end
                end
            end
            SEND: begin
                // Input reopens only after the result leaves, so a result
                // handshake and a new product never share a cycle.
                if (bus.out_ready) begin
                    vld_nxt   = 1'b0;
                    rdy_nxt   = 1'b1;
                    state_nxt = ACC;
                end
            end
            default: begin
                state_nxt = INIT;
            end
        endcase
    end

    // p0: accumulator / input side, p1: registered group result
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= INIT;
            acc_p0      <= '0;
            cnt_p0      <= '0;
            rdy_p0      <= 1'b0;
            res_data_p1 <= '0;
            res_cnt_p1  <= '0;
            vld_p1      <= 1'b0;
        end else begin
            state       <= state_nxt;
            acc_p0      <= acc_nxt;
            cnt_p0      <= cnt_nxt;
            rdy_p0      <= rdy_nxt;
            res_data_p1 <= res_data_nxt;
            res_cnt_p1  <= res_cnt_nxt;
            vld_p1      <= vld_nxt;
        end
    end

    assign bus.in_ready  = rdy_p0;
    assign bus.out_valid = vld_p1;
    assign bus.out_data  = res_data_p1;
    assign bus.out_cnt   = res_cnt_p1;

endmodule

// File: tb/tb_mul_result_accumulator.sv
// Scoreboard bench for mul_result_accumulator: expected group results are queued
// as products are driven and popped when the DUT presents a result.
module tb_mul_result_accumulator;
    localparam int DATA_W = 64;
    localparam int N      = 4;
    localparam int ACC_W  = 66;
    localparam int CNT_W  = 3;

    typedef struct packed {
        logic [ACC_W-1:0] data;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    mul_result_accumulator_if #(.DATA_W(DATA_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

    mul_result_accumulator #(.DATA_W(DATA_W), .N(N), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Called and returning at a falling edge; in_valid drops after the accept.
    task automatic send_beat(input logic [DATA_W-1:0] d, input logic last, output bit ok);
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        for (int i = 0; i < 20; i++) begin
            if (bus.in_ready === 1'b1) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.out_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (2) begin
            @(negedge clk);
            tests++;
            if ({bus.in_ready, bus.out_valid, bus.out_data, bus.out_cnt} !== '0) begin
                fails++;
                $display("FAIL reset_outputs: in_ready=%0b out_valid=%0b out_data=%0h out_cnt=%0d, required all 0",
                         bus.in_ready, bus.out_valid, bus.out_data, bus.out_cnt);
            end
        end
        rst = 1'b0;
        tests++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_release_first: in_ready=%0b out_valid=%0b, required 0 0", bus.in_ready, bus.out_valid);
        end
        @(negedge clk);
        tests++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_release_second: in_ready=%0b out_valid=%0b, required 1 0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_full_group();
        logic [DATA_W-1:0] v[4] = '{64'd6, 64'd15, 64'd100, 64'd1};
        logic [ACC_W-1:0]  esum = '0;
        exp_t              e;
        bit                ok;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) esum += ACC_W'(v[i]);
        exp_q.push_back(exp_t'{esum, CNT_W'(4)});
        for (int i = 0; i < 4; i++) begin
            send_beat(v[i], 1'b0, ok);
            tests++;
            if (!ok) begin
                fails++;
                $display("FAIL full_accept: beat %0d in_ready=%0b, required 1", i, bus.in_ready);
            end
        end
        e = exp_q.pop_front();
        tests++;
        if ({bus.out_valid, bus.in_ready} !== 2'b10) begin
            fails++;
            $display("FAIL full_result_cycle: out_valid=%0b in_ready=%0b, required 1 0", bus.out_valid, bus.in_ready);
        end
        tests++;
        if (bus.out_data !== e.data || bus.out_cnt !== e.cnt) begin
            fails++;
            $display("FAIL full_result: data=%0d cnt=%0d, required %0d %0d", bus.out_data, bus.out_cnt, e.data, e.cnt);
        end
        @(negedge clk);
        tests++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            fails++;
            $display("FAIL full_after_send: out_valid=%0b in_ready=%0b, required 0 1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_early_close();
        logic [DATA_W-1:0] v[3]    = '{64'd7, 64'd9, 64'd5};
        logic              last[3] = '{1'b0, 1'b1, 1'b1};
        logic [ACC_W-1:0]  esum = '0;
        int                ecnt = 0;
        exp_t              e;
        bit                ok;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            esum += ACC_W'(v[i]);
            ecnt++;
            if (last[i]) begin
                exp_q.push_back(exp_t'{esum, CNT_W'(ecnt)});
                esum = '0;
                ecnt = 0;
            end
            send_beat(v[i], last[i], ok);
            if (last[i]) begin
                wait_out(ok);
                tests++;
                if (!ok) begin
                    fails++;
                    $display("FAIL early_timeout: out_valid=%0b, required 1", bus.out_valid);
                end else begin
                    e = exp_q.pop_front();
                    tests++;
                    if (bus.out_data !== e.data || bus.out_cnt !== e.cnt) begin
                        fails++;
                        $display("FAIL early_result: data=%0d cnt=%0d, required %0d %0d",
                                 bus.out_data, bus.out_cnt, e.data, e.cnt);
                    end
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [DATA_W-1:0] v[4] = '{64'd10, 64'd20, 64'd5, 64'd5};
        logic [ACC_W-1:0]  esum = '0;
        exp_t              e;
        bit                ok;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) esum += ACC_W'(v[i]);
        exp_q.push_back(exp_t'{esum, CNT_W'(4)});
        for (int i = 0; i < 4; i++) send_beat(v[i], 1'b0, ok);
        e = exp_q.pop_front();
        bus.in_valid = 1'b1;
        bus.in_data  = 64'd99;
        bus.in_last  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tests++;
            if ({bus.out_valid, bus.in_ready, bus.out_data, bus.out_cnt} !== {2'b10, e.data, e.cnt}) begin
                fails++;
                $display("FAIL bp_hold cycle %0d: out_valid=%0b in_ready=%0b data=%0d cnt=%0d, required 1 0 %0d %0d",
                         k, bus.out_valid, bus.in_ready, bus.out_data, bus.out_cnt, e.data, e.cnt);
            end
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        tests++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            fails++;
            $display("FAIL bp_release: out_valid=%0b in_ready=%0b, required 0 1", bus.out_valid, bus.in_ready);
        end
        exp_q.push_back(exp_t'{ACC_W'(1), CNT_W'(1)});
        send_beat(64'd1, 1'b1, ok);
        wait_out(ok);
        e = exp_q.pop_front();
        tests++;
        if (!ok || bus.out_data !== e.data || bus.out_cnt !== e.cnt) begin
            fails++;
            $display("FAIL bp_not_absorbed: valid=%0b data=%0d cnt=%0d, required 1 %0d %0d",
                     bus.out_valid, bus.out_data, bus.out_cnt, e.data, e.cnt);
        end
        @(negedge clk);
    endtask

    task automatic test_width();
        logic [DATA_W-1:0] mx = '1;
        logic [ACC_W-1:0]  esum = '0;
        exp_t              e;
        bit                ok;
        bus.out_ready = 1'b1;
        for (int i = 0; i < N; i++) esum += ACC_W'(mx);
        exp_q.push_back(exp_t'{esum, CNT_W'(N)});
        for (int i = 0; i < N; i++) send_beat(mx, 1'b0, ok);
        wait_out(ok);
        e = exp_q.pop_front();
        tests++;
        if (!ok || bus.out_data !== e.data || bus.out_cnt !== e.cnt) begin
            fails++;
            $display("FAIL width_max: valid=%0b data=%0h cnt=%0d, required 1 %0h %0d",
                     bus.out_valid, bus.out_data, bus.out_cnt, e.data, e.cnt);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_group();
        exp_t e;
        bit   ok;
        bus.out_ready = 1'b1;
        send_beat(64'd3, 1'b0, ok);
        send_beat(64'd4, 1'b0, ok);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== '0) begin
            fails++;
            $display("FAIL midrst_clear: out_valid=%0b data=%0d, required 0 0", bus.out_valid, bus.out_data);
        end
        exp_q.push_back(exp_t'{ACC_W'(10), CNT_W'(1)});
        send_beat(64'd10, 1'b1, ok);
        wait_out(ok);
        e = exp_q.pop_front();
        tests++;
        if (!ok || bus.out_data !== e.data || bus.out_cnt !== e.cnt) begin
            fails++;
            $display("FAIL midrst_result: valid=%0b data=%0d cnt=%0d, required 1 %0d %0d",
                     bus.out_valid, bus.out_data, bus.out_cnt, e.data, e.cnt);
        end
        @(negedge clk);
        tests++;
        if (bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL midrst_no_stale: out_valid=%0b, required 0", bus.out_valid);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_full_group();
        test_early_close();
        test_backpressure();
        test_width();
        test_reset_mid_group();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d results outstanding, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
